// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared states, opcodes and datapath select encodings for the multicycle MIPS control
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_J     = 6'd2;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;

  localparam logic [1:0] SRCB_REGB    = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SL2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       ir_write;
    logic       alu_src_a;
    logic       reg_write;
    logic       reg_dst;
    logic [1:0] pc_source;
    logic [1:0] alu_op;
    logic [1:0] alu_src_b;
  } ctrl_t;

  function automatic logic op_supported(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ)   || (op == OP_J);
  endfunction

endpackage

// File: rtl/mips_ctrl_outdecode.sv
// rtl/mips_ctrl_outdecode.sv - combinational state to datapath strobe decode
module mips_ctrl_outdecode
  import mips_ctrl_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_source = PCSRC_ALU;
        // IR and PC update only once the instruction word has actually arrived
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SL2;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REGB;
        ctrl.alu_op    = ALUOP_FUNC;
      end
      S_RWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// rtl/mips_multicycle_control.sv - multicycle MIPS main control FSM with memory-ready stalls
module mips_multicycle_control
  import mips_ctrl_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic [5:0] Op,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic       ALUSrcA,
  output logic       RegWrite,
  output logic       RegDst,
  output logic [1:0] PCSource,
  output logic [1:0] ALUOp,
  output logic [1:0] ALUSrcB,
  output logic       IllegalOp,
  output logic [3:0] State
);

  state_t state;
  ctrl_t  dec;
  ctrl_t  ctrl;
  logic   unused_zero;

  // Zero only qualifies PCWriteCond, and that AND lives in the datapath
  assign unused_zero = Zero;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_FETCH;
    end else begin
      case (state)
        S_FETCH:  if (MemReady) state <= S_DECODE;
        S_DECODE: begin
          case (Op)
            OP_RTYPE:     state <= S_EXEC;
            OP_LW, OP_SW: state <= S_MEMADR;
            OP_BEQ:       state <= S_BRANCH;
            OP_J:         state <= S_JUMP;
            default:      state <= S_FETCH;
          endcase
        end
        S_MEMADR: begin
          if (Op == OP_LW)      state <= S_MEMRD;
          else if (Op == OP_SW) state <= S_MEMWR;
          else                  state <= S_FETCH;
        end
        S_MEMRD:  if (MemReady) state <= S_MEMWB;
        S_MEMWR:  if (MemReady) state <= S_FETCH;
        S_EXEC:   state <= S_RWB;
        default:  state <= S_FETCH;
      endcase
    end
  end

  mips_ctrl_outdecode u_outdecode (
    .state     (state),
    .mem_ready (MemReady),
    .ctrl      (dec)
  );

  // Gating with reset_n kills FETCH's MemRead and any in-flight write the instant reset asserts
  assign ctrl = reset_n ? dec : '0;

  assign PCWrite     = ctrl.pc_write;
  assign PCWriteCond = ctrl.pc_write_cond;
  assign IorD        = ctrl.i_or_d;
  assign MemRead     = ctrl.mem_read;
  assign MemWrite    = ctrl.mem_write;
  assign MemtoReg    = ctrl.mem_to_reg;
  assign IRWrite     = ctrl.ir_write;
  assign ALUSrcA     = ctrl.alu_src_a;
  assign RegWrite    = ctrl.reg_write;
  assign RegDst      = ctrl.reg_dst;
  assign PCSource    = ctrl.pc_source;
  assign ALUOp       = ctrl.alu_op;
  assign ALUSrcB     = ctrl.alu_src_b;
  assign IllegalOp   = reset_n && (state == S_DECODE) && !op_supported(Op);
  assign State       = state;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// tb/tb_mips_multicycle_control.sv - randomized self-checking bench for mips_multicycle_control
module tb_mips_multicycle_control;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [5:0] Op;
  logic       Zero;
  logic       MemReady;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
  logic       IRWrite, ALUSrcA, RegWrite, RegDst, IllegalOp;
  logic [1:0] PCSource, ALUOp, ALUSrcB;
  logic [3:0] State;

  int ncmp = 0;
  int nfail = 0;
  int rw_cnt, mw_cnt, redirect;

  localparam int P_F = 0, P_D = 1, P_MA = 2, P_MR = 3, P_WB = 4;
  localparam int P_MW = 5, P_EX = 6, P_RWB = 7, P_BR = 8, P_J = 9;

  mips_multicycle_control dut (
    .clock(clock), .reset_n(reset_n), .Op(Op), .Zero(Zero), .MemReady(MemReady),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemtoReg(MemtoReg), .IRWrite(IRWrite), .ALUSrcA(ALUSrcA),
    .RegWrite(RegWrite), .RegDst(RegDst), .PCSource(PCSource), .ALUOp(ALUOp),
    .ALUSrcB(ALUSrcB), .IllegalOp(IllegalOp), .State(State)
  );

  always #5 clock = ~clock;

  function automatic logic legal(input logic [5:0] op);
    return op == 6'd0 || op == 6'd35 || op == 6'd43 || op == 6'd4 || op == 6'd2;
  endfunction

  function automatic logic [18:0] observed();
    return {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
            ALUSrcA, RegWrite, RegDst, PCSource, ALUOp, ALUSrcB, IllegalOp};
  endfunction

  // Output table written from the per-state strobe list; anything unlisted is 0
  function automatic logic [18:0] expected(input int ph, input logic mr, input logic [5:0] op);
    logic pcw = 0, pcwc = 0, iord = 0, mrd = 0, mwr = 0, m2r = 0, irw = 0;
    logic asa = 0, rw = 0, rd = 0, ill = 0;
    logic [1:0] pcs = 0, aop = 0, asb = 0;
    case (ph)
      P_F:   begin mrd = 1; asb = 2'b01; irw = mr; pcw = mr; end
      P_D:   begin asb = 2'b11; ill = !legal(op); end
      P_MA:  begin asa = 1; asb = 2'b10; end
      P_MR:  begin mrd = 1; iord = 1; end
      P_MW:  begin mwr = 1; iord = 1; end
      P_WB:  begin rw = 1; m2r = 1; end
      P_EX:  begin asa = 1; aop = 2'b10; end
      P_RWB: begin rw = 1; rd = 1; end
      P_BR:  begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
      P_J:   begin pcw = 1; pcs = 2'b10; end
      default: ;
    endcase
    return {pcw, pcwc, iord, mrd, mwr, m2r, irw, asa, rw, rd, pcs, aop, asb, ill};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, check mid-cycle, then advance past the next rising edge
  task automatic step(input int ph, input logic mr, input logic [5:0] op_drive,
                      input logic [5:0] op_instr, input logic z);
    Op = op_drive; MemReady = mr; Zero = z;
    #1;
    check($sformatf("state(ph%0d)", ph), {28'd0, State}, ph);
    check($sformatf("outputs(ph%0d)", ph), {13'd0, observed()}, {13'd0, expected(ph, mr, op_instr)});
    if (RegWrite) rw_cnt++;
    if (MemWrite) mw_cnt++;
    if (ph == P_BR) redirect = int'(PCWrite | (PCWriteCond & Zero));
    @(posedge clock); #1;
  endtask

  // Model: an instruction is a list of phases; memory phases repeat while not ready
  task automatic run_instr(input logic [5:0] op, input int fs, input int ms, input logic z);
    int ph[$];
    int nst;
    logic mr;
    logic [5:0] opd;
    ph = '{P_F, P_D};
    case (op)
      6'd0:  ph = '{P_F, P_D, P_EX, P_RWB};
      6'd35: ph = '{P_F, P_D, P_MA, P_MR, P_WB};
      6'd43: ph = '{P_F, P_D, P_MA, P_MW};
      6'd4:  ph = '{P_F, P_D, P_BR};
      6'd2:  ph = '{P_F, P_D, P_J};
      default: ;
    endcase
    rw_cnt = 0; mw_cnt = 0; redirect = -1;
    foreach (ph[i]) begin
      nst = (ph[i] == P_F) ? fs : (ph[i] == P_MR || ph[i] == P_MW) ? ms : 0;
      for (int c = 0; c <= nst; c++) begin
        if (ph[i] == P_F || ph[i] == P_MR || ph[i] == P_MW) mr = (c == nst);
        else mr = 1'($urandom);
        opd = (ph[i] == P_D || ph[i] == P_MA) ? op : 6'($urandom);
        step(ph[i], mr, opd, op, (ph[i] == P_BR) ? z : 1'($urandom));
      end
    end
    check($sformatf("back_to_fetch(op%0d)", op), {28'd0, State}, P_F);
    check($sformatf("regwrite_pulses(op%0d)", op), rw_cnt,
          (op == 6'd0 || op == 6'd35) ? 1 : 0);
    check($sformatf("memwrite_cycles(op%0d)", op), mw_cnt, (op == 6'd43) ? ms + 1 : 0);
    if (op == 6'd4) check("beq_redirect", redirect, int'(z));
  endtask

  initial begin
    logic [5:0] rop;
    int pick;
    reset_n = 1'b0; Op = 6'd0; Zero = 1'b0; MemReady = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("reset_state", {28'd0, State}, 0);
    check("reset_outputs", {13'd0, observed()}, 0);
    @(negedge clock);
    reset_n = 1'b1;

    run_instr(6'd0, 0, 0, 1'b0);
    run_instr(6'd35, 0, 2, 1'b0);
    run_instr(6'd4, 0, 0, 1'b1);
    run_instr(6'd4, 0, 0, 1'b0);
    run_instr(6'd2, 3, 0, 1'b0);
    run_instr(6'd63, 0, 0, 1'b0);
    run_instr(6'd43, 1, 1, 1'b0);

    // Reset asserted mid-cycle while a store is held in MEMWR
    step(P_F, 1'b1, 6'd0, 6'd43, 1'b0);
    step(P_D, 1'b1, 6'd43, 6'd43, 1'b0);
    step(P_MA, 1'b1, 6'd43, 6'd43, 1'b0);
    Op = 6'd43; MemReady = 1'b0; #1;
    check("memwr_before_reset", {31'd0, MemWrite}, 1);
    reset_n = 1'b0; #1;
    check("memwrite_on_reset", {31'd0, MemWrite}, 0);
    check("state_on_reset", {28'd0, State}, 0);
    check("outputs_on_reset", {13'd0, observed()}, 0);
    @(posedge clock); #1;
    check("outputs_held_reset", {13'd0, observed()}, 0);
    @(negedge clock);
    reset_n = 1'b1;
    run_instr(6'd35, 0, 0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      pick = $urandom_range(0, 5);
      case (pick)
        0: rop = 6'd0;
        1: rop = 6'd35;
        2: rop = 6'd43;
        3: rop = 6'd4;
        4: rop = 6'd2;
        default: begin
          rop = 6'($urandom);
          while (legal(rop)) rop = 6'($urandom);
        end
      endcase
      run_instr(rop, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
